// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - DEPTH-stage MAC-array control delay line with stall/flush
// Optional in-flight status (BUSY, PEND_CNT) under `CTRLPIPE_STATUS_EN.
module ctrl_pipe #(
  parameter int DEPTH = 2,
  parameter int SHW   = 5,
  parameter int IDXW  = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic            FLUSH,
  input  logic            START_CALC0,
  input  logic            ILoad0,
  input  logic            WLoad0,
  input  logic [SHW-1:0]  shamt0,
  input  logic [IDXW-1:0] ICOL0,
  input  logic [IDXW-1:0] WROW0,
  input  logic [IDXW-1:0] ODST0,
  output logic            START_CALC1,
  output logic            ILoad1,
  output logic            WLoad1,
  output logic [SHW-1:0]  shamt1,
  output logic [IDXW-1:0] ICOL1,
  output logic [IDXW-1:0] WROW1,
  output logic [IDXW-1:0] ODST1
`ifdef CTRLPIPE_STATUS_EN
  ,
  output logic            BUSY,
  output logic [3:0]      PEND_CNT
`endif
);

  localparam int BW = 3 + SHW + 3 * IDXW;

  logic [BW-1:0] stage_q [DEPTH];
  logic [BW-1:0] stage_d [DEPTH];
  logic [BW-1:0] in_bundle;

  assign in_bundle = {START_CALC0, ILoad0, WLoad0, shamt0, ICOL0, WROW0, ODST0};

  // Next-state of every stage; flush outranks stall, stall outranks shift.
  always_comb begin
    if (FLUSH)      stage_d[0] = '0;
    else if (STALL) stage_d[0] = stage_q[0];
    else            stage_d[0] = in_bundle;
    for (int k = 1; k < DEPTH; k++) begin
      if (FLUSH)      stage_d[k] = '0;
      else if (STALL) stage_d[k] = stage_q[k];
      else            stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
    end
  end

  assign {START_CALC1, ILoad1, WLoad1, shamt1, ICOL1, WROW1, ODST1} = stage_q[DEPTH-1];

`ifdef CTRLPIPE_STATUS_EN
  logic [3:0] pend_d;
  logic       busy_d;

  // Status is derived from post-update stage contents so it lines up with them.
  always_comb begin
    pend_d = '0;
    busy_d = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      pend_d = pend_d + {3'b000, stage_d[k][BW-1]};
      busy_d = busy_d | (|stage_d[k][BW-1 -: 3]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      PEND_CNT <= '0;
      BUSY     <= 1'b0;
    end else begin
      PEND_CNT <= pend_d;
      BUSY     <= busy_d;
    end
  end
`endif

endmodule
